parity_frame_checker: RTL and testbench

- Sequential consumer that sits directly downstream of the combinational XOR parity generator stage.
- Accepts data words, each with its upstream-computed even-parity bit, over a valid/ready handshake.
- Checks each word, groups words into fixed-length frames and emits one registered per-frame verdict.
- Keeps a saturating lifetime error counter.

---
 rtl/parity_frame_checker_if.sv | 46 ++++
 rtl/parity_frame_checker.sv | 138 +++++++++++++
 tb/tb_parity_frame_checker.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_checker_if.sv
// Handshake bundle for the parity frame checker.
// Both streams use the same valid/ready rule: a transfer happens on a rising
// clock edge where valid && ready are both high. A source holds its payload
// stable while valid is high and ready is low; the sink may change ready freely.
interface parity_frame_checker_if #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    // Word stream into the checker
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;

    // Per-frame verdict stream out of the checker
    logic              out_valid;
    logic              out_ready;
    logic              out_frame_ok;
    logic [CNT_W-1:0]  out_bad_words;

    // Producer of words / consumer of verdicts
    modport master (
        output in_valid,
        output in_data,
        output in_par,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_frame_ok,
        input  out_bad_words
    );

    // The checker itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_par,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_frame_ok,
        output out_bad_words
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Parity frame checker: consumes data words with their even-parity bits,
// groups them into FRAME_LEN-word frames and reports one verdict per frame
// (all-good flag and bad-word count). A saturating lifetime counter tracks
// every bad word accepted. All outputs come straight from flops.
module parity_frame_checker #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_frame_checker_if.slave bus,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic                 ok_q, ok_d;
    logic [CNT_W-1:0]     bad_words_q, bad_words_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 word_bad;
    logic [CNT_W-1:0]     acc_sum;

    // Next-state and next-output computation for the frame FSM and counters
    always_comb begin
        accept   = bus.in_valid && in_ready_q;
        word_bad = (^bus.in_data) ^ bus.in_par;
        acc_sum  = acc_q + CNT_W'(word_bad);

        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        ok_d        = ok_q;
        bad_words_d = bad_words_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d = CNT_W'(1);
                    acc_d = CNT_W'(word_bad);
                    if (FRAME_LEN == 1) begin
                        // A one-word frame is complete on its first word
                        ok_d        = !word_bad;
                        bad_words_d = CNT_W'(word_bad);
                        state_d     = S_REPORT;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    acc_d = acc_sum;
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_q == LAST_IDX) begin
                        ok_d        = (acc_sum == '0);
                        bad_words_d = acc_sum;
                        state_d     = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                // Verdict stays frozen until the consumer takes it
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                acc_d   = '0;
            end
        endcase

        // Lifetime counter sticks at its maximum instead of wrapping
        if (accept && word_bad && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end

        // Handshake/status outputs are registered versions of the next state
        in_ready_d  = (state_d != S_REPORT);
        out_valid_d = (state_d == S_REPORT);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any partial frame or verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            ok_q        <= 1'b0;
            bad_words_q <= '0;
            err_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            ok_q        <= ok_d;
            bad_words_q <= bad_words_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_frame_ok  = ok_q;
    assign bus.out_bad_words = bad_words_q;
    assign err_count         = err_q;
    assign busy              = busy_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker. Three instances share one stimulus stream:
// d0 = default build, d1 = 2-bit error counter, d2 = one-word frames.
// A frame-level reference model per instance predicts every output each cycle.
module tb_parity_frame_checker;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_par;
    logic       out_ready;

    always #5 clk = ~clk;

    parity_frame_checker_if #(.DATA_W(8), .FRAME_LEN(4)) if0 ();
    parity_frame_checker_if #(.DATA_W(8), .FRAME_LEN(4)) if1 ();
    parity_frame_checker_if #(.DATA_W(8), .FRAME_LEN(1)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
    assign if0.in_par = in_par;      assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_data = in_data;
    assign if1.in_par = in_par;      assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_data = in_data;
    assign if2.in_par = in_par;      assign if2.out_ready = out_ready;

    logic [7:0] err0, err2;
    logic [1:0] err1;
    logic       busy0, busy1, busy2;
    logic [1:0] dbg0, dbg1, dbg2;

    parity_frame_checker #(.DATA_W(8), .FRAME_LEN(4), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .err_count(err0), .busy(busy0), .dbg_state(dbg0));
    parity_frame_checker #(.DATA_W(8), .FRAME_LEN(4), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .err_count(err1), .busy(busy1), .dbg_state(dbg1));
    parity_frame_checker #(.DATA_W(8), .FRAME_LEN(1), .ERR_CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .bus(if2), .err_count(err2), .busy(busy2), .dbg_state(dbg2));

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance, words collected in the current frame,
    // bad words among them, a pending verdict, and the lifetime count.
    int fl[3]   = '{4, 4, 1};
    int emax[3] = '{255, 3, 255};
    int m_pend[3];
    int m_cnt[3];
    int m_bads[3];
    int m_ok[3];
    int m_vbad[3];
    int m_err[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model over one rising edge using the inputs now applied
    task automatic model_edge();
        int b;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_pend[d] = 0; m_cnt[d] = 0; m_bads[d] = 0;
                m_ok[d] = 0; m_vbad[d] = 0; m_err[d] = 0;
            end else if (m_pend[d] != 0) begin
                if (out_ready) m_pend[d] = 0;
            end else if (in_valid) begin
                b = $countones(in_data) % 2;
                b = (b + int'(in_par)) % 2;
                m_cnt[d]++;
                m_bads[d] += b;
                if (b == 1 && m_err[d] < emax[d]) m_err[d]++;
                if (m_cnt[d] == fl[d]) begin
                    m_pend[d] = 1;
                    m_ok[d]   = (m_bads[d] == 0) ? 1 : 0;
                    m_vbad[d] = m_bads[d];
                    m_cnt[d]  = 0;
                    m_bads[d] = 0;
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic ir, input logic ov, input logic bsy,
                             input logic ok, input logic [31:0] bw, input logic [31:0] err);
        chk($sformatf("d%0d_in_ready", d), 32'(ir), 32'(m_pend[d] == 0));
        chk($sformatf("d%0d_out_valid", d), 32'(ov), 32'(m_pend[d] != 0));
        chk($sformatf("d%0d_busy", d), 32'(bsy), 32'(m_pend[d] != 0 || m_cnt[d] > 0));
        chk($sformatf("d%0d_frame_ok", d), 32'(ok), 32'(m_ok[d]));
        chk($sformatf("d%0d_bad_words", d), bw, 32'(m_vbad[d]));
        chk($sformatf("d%0d_err_count", d), err, 32'(m_err[d]));
    endtask

    task automatic compare_all();
        check_dut(0, if0.in_ready, if0.out_valid, busy0, if0.out_frame_ok, 32'(if0.out_bad_words), 32'(err0));
        check_dut(1, if1.in_ready, if1.out_valid, busy1, if1.out_frame_ok, 32'(if1.out_bad_words), 32'(err1));
        check_dut(2, if2.in_ready, if2.out_valid, busy2, if2.out_frame_ok, 32'(if2.out_bad_words), 32'(err2));
    endtask

    // One clock: model update, edge, then compare just after the edge
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    // Present one word until instance d accepts it (bounded wait)
    task automatic send_word(input int d, input logic [7:0] data, input logic par);
        bit done = 0;
        bit will_accept;
        in_valid = 1'b1;
        in_data  = data;
        in_par   = par;
        for (int i = 0; i < 20 && !done; i++) begin
            will_accept = (m_pend[d] == 0);
            cycle();
            if (will_accept) done = 1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=0 exp=1");
        end
    endtask

    initial begin
        int n;
        int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0; out_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m_pend[d] = 0; m_cnt[d] = 0; m_bads[d] = 0;
            m_ok[d] = 0; m_vbad[d] = 0; m_err[d] = 0;
        end
        cycle();
        do_reset();
        chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("rst_err", 32'(err0), 32'd0);

        // Clean frame, back-to-back, consumer always ready
        send_word(0, 8'h01, 1'b1);
        send_word(0, 8'h03, 1'b0);
        send_word(0, 8'hFF, 1'b0);
        send_word(0, 8'h00, 1'b0);
        chk("clean_valid", 32'(if0.out_valid), 32'd1);
        chk("clean_ok", 32'(if0.out_frame_ok), 32'd1);
        chk("clean_bad", 32'(if0.out_bad_words), 32'd0);
        chk("clean_err", 32'(err0), 32'd0);
        cycle();
        chk("clean_valid_drop", 32'(if0.out_valid), 32'd0);

        // Errored frame: three bad words
        send_word(0, 8'h01, 1'b0);
        send_word(0, 8'h03, 1'b0);
        send_word(0, 8'h07, 1'b0);
        send_word(0, 8'h00, 1'b1);
        chk("err_ok", 32'(if0.out_frame_ok), 32'd0);
        chk("err_bad", 32'(if0.out_bad_words), 32'd3);
        chk("err_count3", 32'(err0), 32'd3);
        cycle();

        // Backpressure: verdict held, new words refused
        out_ready = 1'b0;
        send_word(0, 8'h00, 1'b0);
        send_word(0, 8'h00, 1'b0);
        send_word(0, 8'h01, 1'b0);
        send_word(0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_par   = 1'($urandom_range(0, 1));
            cycle();
            chk("bp_in_ready", 32'(if0.in_ready), 32'd0);
            chk("bp_valid", 32'(if0.out_valid), 32'd1);
            chk("bp_hold_bad", 32'(if0.out_bad_words), 32'd1);
            chk("bp_hold_ok", 32'(if0.out_frame_ok), 32'd0);
            chk("bp_err", 32'(err0), 32'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("bp_release", 32'(if0.out_valid), 32'd0);
        send_word(0, 8'h11, 1'b0);
        send_word(0, 8'h10, 1'b1);
        send_word(0, 8'h30, 1'b0);
        send_word(0, 8'h70, 1'b1);
        chk("bp_next_ok", 32'(if0.out_frame_ok), 32'd1);
        chk("bp_next_valid", 32'(if0.out_valid), 32'd1);
        cycle();

        // Gaps then reset mid-frame
        do_reset();
        send_word(0, 8'h00, 1'b0);
        send_word(0, 8'h03, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        send_word(0, 8'h01, 1'b0);
        chk("gap_err_pre", 32'(err0), 32'd1);
        do_reset();
        chk("gap_err", 32'(err0), 32'd0);
        chk("gap_busy", 32'(busy0), 32'd0);
        chk("gap_valid", 32'(if0.out_valid), 32'd0);
        send_word(0, 8'h01, 1'b1);
        send_word(0, 8'h03, 1'b0);
        send_word(0, 8'hFF, 1'b0);
        send_word(0, 8'h00, 1'b0);
        chk("gap_next_ok", 32'(if0.out_frame_ok), 32'd1);
        chk("gap_next_valid", 32'(if0.out_valid), 32'd1);
        cycle();

        // Saturation of the 2-bit counter
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send_word(1, 8'h01, 1'b0);
            chk("sat_err", 32'(err1), 32'(sat_exp[k]));
        end
        cycle();

        // One-word frames: continuous valid accepts every other cycle
        do_reset();
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_par   = 1'($urandom_range(0, 1));
            if (if2.in_ready) n++;
            cycle();
        end
        in_valid = 1'b0;
        chk("fl1_accepts", 32'(n), 32'd4);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_par    = ($urandom_range(0, 3) == 0) ? ~(^in_data) : (^in_data);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
